// File: rtl/user_obi_arbiter.sv
// Round-robin OBI arbiter: serialises NumMgr upstream managers onto one
// downstream OBI port and routes responses back in order via an ID FIFO.
module user_obi_arbiter #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumMgr-1:0]                     sbr_req_i,
    input  logic [NumMgr-1:0][AddrWidth-1:0]      sbr_addr_i,
    input  logic [NumMgr-1:0]                     sbr_we_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]    sbr_be_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]      sbr_wdata_i,
    output logic [NumMgr-1:0]                     sbr_gnt_o,
    output logic [NumMgr-1:0]                     sbr_rvalid_o,
    output logic [DataWidth-1:0]                  sbr_rdata_o,
    output logic                                  sbr_err_o,
    output logic                                  mgr_req_o,
    output logic [AddrWidth-1:0]                  mgr_addr_o,
    output logic                                  mgr_we_o,
    output logic [DataWidth/8-1:0]                mgr_be_o,
    output logic [DataWidth-1:0]                  mgr_wdata_o,
    input  logic                                  mgr_gnt_i,
    input  logic                                  mgr_rvalid_i,
    input  logic [DataWidth-1:0]                  mgr_rdata_i,
    input  logic                                  mgr_err_i,
    output logic                                  unexp_rsp_o
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0]                rr_ptr_q, rr_ptr_d;
    logic                           lock_q, lock_d;
    logic [IdxW-1:0]                lock_idx_q, lock_idx_d;
    logic [MaxTrans-1:0][IdxW-1:0]  fifo_q, fifo_d;
    logic [PtrW-1:0]                wptr_q, wptr_d;
    logic [PtrW-1:0]                rptr_q, rptr_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic                           unexp_q, unexp_d;

    logic [IdxW-1:0]                sel;
    logic [IdxW-1:0]                head;
    logic                           push;
    logic                           pop;
    int unsigned                    cand;

    // Pick the requester: locked index, else first request at or after rr_ptr_q
    always_comb begin
        sel  = rr_ptr_q;
        cand = 0;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int unsigned i = NumMgr; i > 0; i--) begin
            cand = int'(rr_ptr_q) + i - 1;
            if (cand >= NumMgr) cand = cand - NumMgr;
            if (sbr_req_i[cand]) sel = IdxW'(cand);
        end
        if (lock_q) sel = lock_idx_q;
    end

    assign mgr_req_o   = sbr_req_i[sel] & (cnt_q < CntW'(MaxTrans));
    assign mgr_addr_o  = mgr_req_o ? sbr_addr_i[sel]  : '0;
    assign mgr_we_o    = mgr_req_o ? sbr_we_i[sel]    : 1'b0;
    assign mgr_be_o    = mgr_req_o ? sbr_be_i[sel]    : '0;
    assign mgr_wdata_o = mgr_req_o ? sbr_wdata_i[sel] : '0;

    assign push = mgr_req_o & mgr_gnt_i;
    assign pop  = mgr_rvalid_i & (cnt_q != '0);
    assign head = fifo_q[rptr_q];

    assign sbr_rdata_o = mgr_rdata_i;
    assign sbr_err_o   = mgr_err_i;
    assign unexp_rsp_o = unexp_q;

    // Steer grant to the selected manager and response valid to the FIFO head
    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (push) sbr_gnt_o[sel]     = 1'b1;
        if (pop)  sbr_rvalid_o[head] = 1'b1;
    end

    // Next-state: lock, round-robin pointer, ID FIFO and unexpected-response flag
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        unexp_d    = unexp_q;

        if (mgr_req_o && !mgr_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (push) begin
            lock_d = 1'b0;
        end

        if (push) begin
            rr_ptr_d       = (sel == IdxW'(NumMgr - 1)) ? '0 : sel + IdxW'(1);
            fifo_d[wptr_q] = sel;
            wptr_d         = (wptr_q == PtrW'(MaxTrans - 1)) ? '0 : wptr_q + PtrW'(1);
        end

        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxTrans - 1)) ? '0 : rptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (mgr_rvalid_i && (cnt_q == '0)) unexp_d = 1'b1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            fifo_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            unexp_q    <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            unexp_q    <= unexp_d;
        end
    end

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Self-checking bench for user_obi_arbiter (NumMgr=2, MaxTrans=2).
module tb_user_obi_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        sbr_req;
    logic [1:0][31:0]  sbr_addr;
    logic [1:0]        sbr_we;
    logic [1:0][3:0]   sbr_be;
    logic [1:0][31:0]  sbr_wdata;
    logic [1:0]        sbr_gnt;
    logic [1:0]        sbr_rvalid;
    logic [31:0]       sbr_rdata;
    logic              sbr_err;
    logic              mgr_req;
    logic [31:0]       mgr_addr;
    logic              mgr_we;
    logic [3:0]        mgr_be;
    logic [31:0]       mgr_wdata;
    logic              mgr_gnt;
    logic              mgr_rvalid;
    logic [31:0]       mgr_rdata;
    logic              mgr_err;
    logic              unexp_rsp;

    user_obi_arbiter #(
        .NumMgr   (2),
        .AddrWidth(32),
        .DataWidth(32),
        .MaxTrans (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sbr_req_i   (sbr_req),
        .sbr_addr_i  (sbr_addr),
        .sbr_we_i    (sbr_we),
        .sbr_be_i    (sbr_be),
        .sbr_wdata_i (sbr_wdata),
        .sbr_gnt_o   (sbr_gnt),
        .sbr_rvalid_o(sbr_rvalid),
        .sbr_rdata_o (sbr_rdata),
        .sbr_err_o   (sbr_err),
        .mgr_req_o   (mgr_req),
        .mgr_addr_o  (mgr_addr),
        .mgr_we_o    (mgr_we),
        .mgr_be_o    (mgr_be),
        .mgr_wdata_o (mgr_wdata),
        .mgr_gnt_i   (mgr_gnt),
        .mgr_rvalid_i(mgr_rvalid),
        .mgr_rdata_i (mgr_rdata),
        .mgr_err_i   (mgr_err),
        .unexp_rsp_o (unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        exp_req;
        logic        exp_sel;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t        tbl[$];
    int unsigned sb[$];
    logic        unexp_exp;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err,
                       input logic exp_req, input logic exp_sel, input logic [1:0] exp_gnt);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.exp_req = exp_req; v.exp_sel = exp_sel; v.exp_gnt = exp_gnt;
        tbl.push_back(v);
    endtask

    // One cycle: drive after the rising edge, compare on the falling edge.
    task automatic step(input vec_t v);
        logic [1:0]  exp_rv;
        logic [36:0] exp_pl;
        logic        unexp_nxt;
        int unsigned h;
        @(posedge clk);
        #1;
        sbr_req    = v.req;
        mgr_gnt    = v.gnt;
        mgr_rvalid = v.rv;
        mgr_rdata  = v.rdata;
        mgr_err    = v.err;
        @(negedge clk);
        exp_rv    = 2'b00;
        unexp_nxt = unexp_exp;
        if (v.rv) begin
            if (sb.size() > 0) begin
                h = sb.pop_front();
                exp_rv[h] = 1'b1;
            end else begin
                unexp_nxt = 1'b1;
            end
        end
        exp_pl = v.exp_req ? {sbr_we[v.exp_sel], sbr_be[v.exp_sel], sbr_wdata[v.exp_sel]} : '0;
        check("mgr_req",   64'(mgr_req), 64'(v.exp_req));
        check("sbr_gnt",   64'(sbr_gnt), 64'(v.exp_gnt));
        check("mgr_addr",  64'(mgr_addr), v.exp_req ? 64'(sbr_addr[v.exp_sel]) : 64'd0);
        check("mgr_payld", 64'({mgr_we, mgr_be, mgr_wdata}), 64'(exp_pl));
        check("sbr_rvalid", 64'(sbr_rvalid), 64'(exp_rv));
        check("rdata_err", 64'({sbr_err, sbr_rdata}), 64'({v.err, v.rdata}));
        check("unexp_rsp", 64'(unexp_rsp), 64'(unexp_exp));
        unexp_exp = unexp_nxt;
        if (v.exp_gnt == 2'b01) sb.push_back(0);
        if (v.exp_gnt == 2'b10) sb.push_back(1);
    endtask

    task automatic step_args(input logic [1:0] req, input logic gnt, input logic rv,
                             input logic exp_req, input logic exp_sel, input logic [1:0] exp_gnt);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = $urandom; v.err = 1'b0;
        v.exp_req = exp_req; v.exp_sel = exp_sel; v.exp_gnt = exp_gnt;
        step(v);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        unexp_exp  = 1'b0;
        rst_n      = 1'b0;
        sbr_req    = '0;
        mgr_gnt    = 1'b0;
        mgr_rvalid = 1'b0;
        mgr_rdata  = '0;
        mgr_err    = 1'b0;
        sbr_addr[0] = 32'h1000_0000; sbr_we[0] = 1'b1; sbr_be[0] = 4'hF; sbr_wdata[0] = 32'h1111_1111;
        sbr_addr[1] = 32'h0300_0000; sbr_we[1] = 1'b0; sbr_be[1] = 4'h3; sbr_wdata[1] = 32'h2222_2222;

        //  req    gnt   rv    rdata          err   ereq  esel  egnt
        add(2'b00, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00); // idle after reset
        add(2'b10, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'b10); // single mgr1 read
        add(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2'b00); // its response
        add(2'b11, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 2'b01); // fairness
        add(2'b11, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 2'b10);
        add(2'b11, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 2'b01);
        add(2'b11, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 2'b10);
        add(2'b01, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 2'b01);
        add(2'b00, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 2'b00); // rr now at mgr1
        add(2'b01, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 2'b00); // lock on mgr0
        add(2'b11, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 2'b00);
        add(2'b11, 1'b0, 1'b0, 32'h0000_0009, 1'b0, 1'b1, 1'b0, 2'b00);
        add(2'b11, 1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 2'b01);
        add(2'b10, 1'b1, 1'b1, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 2'b10);
        add(2'b00, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 2'b00);
        add(2'b01, 1'b1, 1'b0, 32'h0000_000D, 1'b0, 1'b1, 1'b0, 2'b01); // fill FIFO
        add(2'b10, 1'b1, 1'b0, 32'h0000_000E, 1'b0, 1'b1, 1'b1, 2'b10);
        add(2'b01, 1'b1, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 2'b00); // full stall
        add(2'b01, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 2'b00); // pop while full
        add(2'b01, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 2'b01); // issue resumes
        add(2'b00, 1'b0, 1'b1, 32'h0000_0012, 1'b0, 1'b0, 1'b0, 2'b00);
        add(2'b00, 1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 2'b00);
        add(2'b00, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 2'b00); // unexpected rsp
        add(2'b00, 1'b0, 1'b0, 32'h0000_0015, 1'b0, 1'b0, 1'b0, 2'b00);
        add(2'b00, 1'b0, 1'b0, 32'h0000_0016, 1'b0, 1'b0, 1'b0, 2'b00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mgr_req", 64'(mgr_req), 64'd0);
        check("rst_outputs", 64'({sbr_gnt, sbr_rvalid, unexp_rsp}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset with one transaction outstanding and rr pointing at mgr1
        step_args(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        sbr_req    = 2'b00;
        mgr_gnt    = 1'b0;
        mgr_rvalid = 1'b0;
        sb.delete();
        unexp_exp  = 1'b0;
        @(negedge clk);
        check("midrst_req",   64'(mgr_req), 64'd0);
        check("midrst_unexp", 64'(unexp_rsp), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step_args(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00); // stale response
        step_args(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01); // rr back at mgr0
        step_args(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10); // mgr1 granted normally
        step_args(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step_args(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1);
    end

endmodule
